// File: rtl/wfi_wake_gen.sv
// WFI wake-up generator: synchronizes peripheral interrupt lines, latches rising
// edges as sticky pending bits and issues one PC-release pulse per WFI.
module wfi_wake_gen #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CAUSE_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_wfi_req,
  input  logic [NUM_SRC-1:0] i_irq_src,
  input  logic [NUM_SRC-1:0] i_irq_en,
  input  logic [NUM_SRC-1:0] i_irq_clr,
  output logic               o_sen_pulse,
  output logic               o_sleeping,
  output logic [NUM_SRC-1:0] o_pending,
  output logic [CAUSE_W-1:0] o_wake_cause
);

  typedef enum logic [1:0] {IDLE, SLEEP, WAKE, HOLD} state_t;

  state_t                            r_state;
  state_t                            w_next;
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] r_sync;
  logic [NUM_SRC-1:0]                r_prev;
  logic [NUM_SRC-1:0]                r_rise;
  logic [NUM_SRC-1:0]                r_pending;
  logic [CAUSE_W-1:0]                r_wake_cause;
  logic [NUM_SRC-1:0]                w_synced;
  logic [NUM_SRC-1:0]                w_hit_vec;
  logic                              w_wake_hit;
  logic [CAUSE_W-1:0]                w_cause;

  assign w_synced = r_sync[SYNC_STAGES-1];

  // Synchronizer chain plus a registered edge detect, so a new rising edge
  // reaches the pending bits SYNC_STAGES+1 edges after it is first sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= '0;
      r_rise <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq_src};
      r_prev <= w_synced;
      r_rise <= w_synced & ~r_prev;
    end
  end

  // A fresh edge outranks a same-cycle software clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~i_irq_clr) | r_rise;
    end
  end

  assign w_hit_vec  = r_pending & i_irq_en;
  assign w_wake_hit = |w_hit_vec;

  always_comb begin
    w_cause = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_hit_vec[i]) begin
        w_cause = CAUSE_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_wfi_req) begin
          w_next = w_wake_hit ? WAKE : SLEEP;
        end
      end
      SLEEP: begin
        if (!i_wfi_req) begin
          w_next = IDLE;
        end else if (w_wake_hit) begin
          w_next = WAKE;
        end
      end
      WAKE: w_next = HOLD;
      HOLD: begin
        if (!i_wfi_req) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // The cause is captured on WAKE entry so it is valid alongside the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wake_cause <= '0;
    end else if (w_next == WAKE && r_state != WAKE) begin
      r_wake_cause <= w_cause;
    end
  end

  always_comb begin
    o_sen_pulse = 1'b0;
    o_sleeping  = 1'b0;
    case (r_state)
      SLEEP:   o_sleeping  = 1'b1;
      WAKE:    o_sen_pulse = 1'b1;
      default: ;
    endcase
  end

  assign o_pending    = r_pending;
  assign o_wake_cause = r_wake_cause;

endmodule

// File: tb/tb_wfi_wake_gen.sv
// Directed self-checking bench for wfi_wake_gen; each task drives one scenario
// and compares outputs against hand-computed expectations.
module tb_wfi_wake_gen;

  logic       clk;
  logic       rst_n;
  logic       wfiReq;
  logic [3:0] irqSrc;
  logic [3:0] irqEn;
  logic [3:0] irqClr;
  logic       senPulse;
  logic       sleeping;
  logic [3:0] pending;
  logic [1:0] wakeCause;

  int errors = 0;
  int checks = 0;

  wfi_wake_gen #(
    .NUM_SRC(4),
    .SYNC_STAGES(2),
    .CAUSE_W(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wfi_req   (wfiReq),
    .i_irq_src   (irqSrc),
    .i_irq_en    (irqEn),
    .i_irq_clr   (irqClr),
    .o_sen_pulse (senPulse),
    .o_sleeping  (sleeping),
    .o_pending   (pending),
    .o_wake_cause(wakeCause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    wfiReq = 1'b1;
    irqSrc = 4'b0000;
    irqEn  = 4'b0000;
    irqClr = 4'b0000;
    tick(3);
    checks++;
    if (senPulse !== 1'b0 || sleeping !== 1'b0 || pending !== 4'b0000 || wakeCause !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: sen=%b sleep=%b pend=%b cause=%0d, need all zero",
               senPulse, sleeping, pending, wakeCause);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (sleeping !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_to_sleep: sleeping=%b need 1", sleeping);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (sleeping !== 1'b1 || senPulse !== 1'b0 || pending !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL quiet_sleep[%0d]: sleep=%b sen=%b pend=%b need 1/0/0000",
                 i, sleeping, senPulse, pending);
      end
    end
  endtask

  task automatic test_wake_latency();
    irqEn  = 4'b0100;
    irqSrc = 4'b0100;
    tick(3);
    checks++;
    if (pending !== 4'b0000 || sleeping !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pend_early: pend=%b sleep=%b need 0000/1", pending, sleeping);
    end
    tick();
    checks++;
    if (pending !== 4'b0100 || senPulse !== 1'b0 || sleeping !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pend_edge3: pend=%b sen=%b sleep=%b need 0100/0/1",
               pending, senPulse, sleeping);
    end
    tick();
    checks++;
    if (senPulse !== 1'b1 || wakeCause !== 2'd2 || sleeping !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wake_edge4: sen=%b cause=%0d sleep=%b need 1/2/0",
               senPulse, wakeCause, sleeping);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (senPulse !== 1'b0 || wakeCause !== 2'd2) begin
        errors++;
        $display("[TB] FAIL hold_no_repulse[%0d]: sen=%b cause=%0d need 0/2", i, senPulse, wakeCause);
      end
    end
    wfiReq = 1'b0;
    tick();
    checks++;
    if (senPulse !== 1'b0 || sleeping !== 1'b0 || pending !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL hold_to_idle: sen=%b sleep=%b pend=%b need 0/0/0100",
               senPulse, sleeping, pending);
    end
    irqSrc = 4'b0000;
    irqClr = 4'b0100;
    tick();
    irqClr = 4'b0000;
    checks++;
    if (pending !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL clear_src2: pend=%b need 0000", pending);
    end
    tick(3);
  endtask

  task automatic test_priority_and_clear();
    irqEn  = 4'b1010;
    irqSrc = 4'b1010;
    tick(4);
    checks++;
    if (pending !== 4'b1010 || senPulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dual_pend: pend=%b sen=%b need 1010/0", pending, senPulse);
    end
    wfiReq = 1'b1;
    tick();
    checks++;
    if (senPulse !== 1'b1 || wakeCause !== 2'd1 || sleeping !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fast_wake: sen=%b cause=%0d sleep=%b need 1/1/0",
               senPulse, wakeCause, sleeping);
    end
    tick();
    checks++;
    if (senPulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fast_wake_single: sen=%b need 0", senPulse);
    end
    irqClr = 4'b0010;
    tick();
    irqClr = 4'b0000;
    checks++;
    if (pending !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL w1c_bit1: pend=%b need 1000", pending);
    end
    tick(3);
    checks++;
    if (pending !== 4'b1000 || senPulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL level_no_reset: pend=%b sen=%b need 1000/0", pending, senPulse);
    end
    wfiReq = 1'b0;
    tick();
    irqSrc = 4'b0000;
    irqClr = 4'b1111;
    tick();
    irqClr = 4'b0000;
    checks++;
    if (pending !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL clear_all: pend=%b need 0000", pending);
    end
    tick(3);
  endtask

  task automatic test_disabled_source();
    irqEn  = 4'b0000;
    wfiReq = 1'b1;
    tick();
    checks++;
    if (sleeping !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dis_sleep: sleeping=%b need 1", sleeping);
    end
    irqSrc = 4'b0001;
    tick(4);
    checks++;
    if (pending !== 4'b0001 || senPulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dis_pend: pend=%b sen=%b need 0001/0", pending, senPulse);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (senPulse !== 1'b0 || sleeping !== 1'b1) begin
        errors++;
        $display("[TB] FAIL dis_no_wake[%0d]: sen=%b sleep=%b need 0/1", i, senPulse, sleeping);
      end
    end
    irqEn = 4'b0001;
    tick();
    checks++;
    if (senPulse !== 1'b1 || wakeCause !== 2'd0) begin
      errors++;
      $display("[TB] FAIL enable_wake: sen=%b cause=%0d need 1/0", senPulse, wakeCause);
    end
    wfiReq = 1'b0;
    tick(2);
    irqSrc = 4'b0000;
    irqEn  = 4'b0000;
    irqClr = 4'b1111;
    tick();
    irqClr = 4'b0000;
    tick(3);
  endtask

  task automatic test_set_clear_collision();
    irqSrc = 4'b0001;
    tick(3);
    irqClr = 4'b0001;
    tick();
    irqClr = 4'b0000;
    checks++;
    if (pending !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL set_wins: pend=%b need 0001", pending);
    end
    irqClr = 4'b0001;
    tick();
    irqClr = 4'b0000;
    checks++;
    if (pending !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL clear_after_set: pend=%b need 0000", pending);
    end
    irqSrc = 4'b0000;
    tick(3);
  endtask

  task automatic test_abort();
    wfiReq = 1'b1;
    tick();
    checks++;
    if (sleeping !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_sleep: sleeping=%b need 1", sleeping);
    end
    wfiReq = 1'b0;
    tick();
    checks++;
    if (sleeping !== 1'b0 || senPulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_idle: sleep=%b sen=%b need 0/0", sleeping, senPulse);
    end
    tick(2);
    checks++;
    if (senPulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_no_pulse: sen=%b need 0", senPulse);
    end
    irqSrc = 4'b0100;
    irqEn  = 4'b0100;
    tick(4);
    wfiReq = 1'b1;
    tick();
    checks++;
    if (senPulse !== 1'b1 || wakeCause !== 2'd2) begin
      errors++;
      $display("[TB] FAIL pre_reset_wake: sen=%b cause=%0d need 1/2", senPulse, wakeCause);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (senPulse !== 1'b0 || sleeping !== 1'b0 || pending !== 4'b0000 || wakeCause !== 2'd0) begin
      errors++;
      $display("[TB] FAIL async_abort: sen=%b sleep=%b pend=%b cause=%0d need all zero",
               senPulse, sleeping, pending, wakeCause);
    end
    irqSrc = 4'b0000;
    tick(2);
    rst_n = 1'b1;
    tick();
    checks++;
    if (sleeping !== 1'b1 || senPulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_sleep: sleep=%b sen=%b need 1/0", sleeping, senPulse);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (senPulse !== 1'b0 || pending !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL post_reset_quiet[%0d]: sen=%b pend=%b need 0/0000", i, senPulse, pending);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_wake_latency();
    test_priority_and_clear();
    test_disabled_source();
    test_set_clear_collision();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
